// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
//
// Purpose : bundles the operand-side and result-side valid/ready handshakes of
//           the bit-serial adder sequencer into one interface.
//
// Parameters
//   WIDTH      operand/result width (2..32); must match the attached controller.
//
// Signals (direction as seen from the controller, i.e. the slave modport)
//   in_valid   in   operand beat valid
//   in_ready   out  controller can accept operands
//   a, b       in   WIDTH-bit operands, sampled on the input handshake
//   ci         in   carry-in, sampled on the input handshake
//   sub        in   subtract request (only honoured when SERIAL_ADD_SUB_EN)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   s          out  registered sum
//   co         out  registered carry-out of the MSB slice
//   ovf        out  registered two's-complement overflow
//   busy       out  operation in progress or result pending
//
// Modports
//   master     producer/consumer side (drives operands and out_ready)
//   slave      controller side
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output ci,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  s,
        input  co,
        input  ovf,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  ci,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output s,
        output co,
        output ovf,
        output busy
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose : bit-serial addition sequencer. A single add_full cell is reused
//           once per clock, LSB first, to add two WIDTH-bit operands. The
//           carry is held in a register between slices. Sum, carry-out and
//           signed overflow are registered when the last slice completes.
//
// Configuration macro
//   SERIAL_ADD_SUB_EN  when defined, sub=1 at the input handshake computes
//                      a-b (B is inverted and the carry-in forced to 1).
//                      When undefined, sub is ignored and the block always
//                      computes a+b+ci.
//
// Parameters
//   WIDTH      operand/result width, 2..32 (default 4)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   bus        serial_add_ctrl_if.slave: operand/result handshakes and results
//
// Timing
//   Accept at edge E0, WIDTH RUN cycles, out_valid from edge E0+WIDTH.
//   Back-to-back throughput is one operation every WIDTH+2 cycles.
// -----------------------------------------------------------------------------

// One-bit full adder: the only arithmetic cell in the sequencer.
module add_full (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;

    // Operand B and carry as they enter the shift/carry registers.
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    // Slice outputs of the shared full adder.
    logic               fa_s;
    logic               fa_co;

`ifdef SERIAL_ADD_SUB_EN
    // a - b = a + ~b + 1; the forced carry-in supplies the +1.
    assign b_load = bus.sub ? ~bus.b : bus.b;
    assign c_load = bus.sub | bus.ci;
`else
    assign b_load = bus.b;
    assign c_load = bus.ci;
    // sub has no function in this build; tie it off explicitly.
    logic unused_sub;
    assign unused_sub = bus.sub;
`endif

    add_full u_add_full (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .ci_i (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a missing
        // assignment on any path would otherwise infer a latch.
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        co_d     = co_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                // Sum bits enter at the MSB so that after WIDTH slices the
                // first (LSB) result bit has reached position 0.
                sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
                carry_d  = fa_co;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    s_d     = sum_sr_d;
                    co_d    = fa_co;
                    // Signed overflow: carry into the MSB differs from carry out.
                    ovf_d   = carry_q ^ fa_co;
                    state_d = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            s_q      <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake status is decoded from the state register only, so there is
    // no combinational path from in_valid/out_ready to these outputs.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl. A WIDTH=4 instance is checked every
// cycle against an arithmetic reference model; a WIDTH=8 instance covers the
// wide-operand corner. Hand-computed literals pin the model's results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_add_ctrl;
    localparam int W  = 4;
    localparam int W8 = 8;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W))  bus4 ();
    serial_add_ctrl_if #(.WIDTH(W8)) bus8 ();

    serial_add_ctrl #(.WIDTH(W))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
    serial_add_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: returns {ovf, co, s} for one operation.
    function automatic logic [W+1:0] model_op(input int a, input int b, input bit ci, input bit sub);
        int mask, bv, cin, sum, sv;
        bit sa, sb, ss, co, ovf;
        mask = (1 << W) - 1;
        bv   = b & mask;
        cin  = int'(ci);
        if (sub && SUB_EN) begin
            bv  = ~b & mask;
            cin = 1;
        end
        sum = (a & mask) + bv + cin;
        sv  = sum & mask;
        co  = ((sum >> W) & 1) != 0;
        sa  = ((a  >> (W - 1)) & 1) != 0;
        sb  = ((bv >> (W - 1)) & 1) != 0;
        ss  = ((sv >> (W - 1)) & 1) != 0;
        ovf = (sa == sb) && (ss != sa);
        return {ovf, co, sv[W-1:0]};
    endfunction

    // Transaction-level model of the WIDTH=4 instance.
    typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;
    mphase_e        m_phase = M_IDLE;
    int             m_left  = 0;
    logic [W+1:0]   m_pend  = '0;
    logic [W+1:0]   m_vis   = '0;   // {ovf, co, s} currently visible

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_phase <= M_IDLE;
            m_left  <= 0;
            m_vis   <= '0;
        end else begin
            case (m_phase)
                M_IDLE: if (bus4.in_valid) begin
                    m_phase <= M_RUN;
                    m_left  <= W;
                    m_pend  <= model_op(int'(bus4.a), int'(bus4.b), bus4.ci, bus4.sub);
                end
                M_RUN: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= M_DONE;
                        m_vis   <= m_pend;
                    end
                end
                M_DONE: if (bus4.out_ready) m_phase <= M_IDLE;
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output of the WIDTH=4 instance.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle",
                  {bus4.in_ready, bus4.out_valid, bus4.busy, bus4.ovf, bus4.co, bus4.s},
                  {m_phase == M_IDLE, m_phase == M_DONE, m_phase != M_IDLE, m_vis});
        end
    end

    int last_acc = 0;

    // Issue one operation to the WIDTH=4 instance and wait for out_valid.
    // Called and returns on a falling edge.
    task automatic op4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit ci, input bit sub, output int lat);
        int guard = 0;
        while (!bus4.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus4.in_ready) check("in_ready_wait", bus4.in_ready, 1);
        bus4.a        = a;
        bus4.b        = b;
        bus4.ci       = ci;
        bus4.sub      = sub;
        bus4.in_valid = 1'b1;
        last_acc      = cyc;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           ci;
        bit           sub;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat, acc1, acc2, saw_ov, guard;
        vec_t tbl[4];
        tbl[0] = '{a: 4'h8, b: 4'h8, ci: 1'b0, sub: 1'b0};
        tbl[1] = '{a: 4'hA, b: 4'h5, ci: 1'b1, sub: 1'b0};
        tbl[2] = '{a: 4'h4, b: 4'hC, ci: 1'b1, sub: 1'b1};
        tbl[3] = '{a: 4'hF, b: 4'hF, ci: 1'b1, sub: 1'b0};

        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.ci = 1'b0;
        bus4.sub = 1'b0; bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
        bus8.sub = 1'b0; bus8.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;

        // Reset state
        check("rst_in_ready",  bus4.in_ready,  1);
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_busy",      bus4.busy,      0);
        check("rst_result",    {bus4.ovf, bus4.co, bus4.s}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3 + 5: unsigned fits, signed overflows
        op4(4'h3, 4'h5, 1'b0, 1'b0, lat);
        check("t1_latency", lat, W);
        check("t1_s",   bus4.s,   4'h8);
        check("t1_co",  bus4.co,  1'b0);
        check("t1_ovf", bus4.ovf, 1'b1);

        // Back-to-back: F+1, then 7+7+1
        op4(4'hF, 4'h1, 1'b0, 1'b0, lat);
        acc1 = last_acc;
        check("t2a_s",   bus4.s,   4'h0);
        check("t2a_co",  bus4.co,  1'b1);
        check("t2a_ovf", bus4.ovf, 1'b0);
        op4(4'h7, 4'h7, 1'b1, 1'b0, lat);
        acc2 = last_acc;
        check("t2b_s",   bus4.s,   4'hF);
        check("t2b_co",  bus4.co,  1'b0);
        check("t2b_ovf", bus4.ovf, 1'b1);
        check("t2_spacing", acc2 - acc1, W + 2);

        // Backpressure in DONE with in_valid pulsed
        @(negedge clk);
        bus4.out_ready = 1'b0;
        op4(4'h2, 4'h3, 1'b0, 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            bus4.a = 4'h1; bus4.b = 4'h1; bus4.in_valid = 1'b1;
            @(negedge clk);
            check("bp_in_ready",  bus4.in_ready,  0);
            check("bp_out_valid", bus4.out_valid, 1);
            check("bp_result",    {bus4.ovf, bus4.co, bus4.s}, {1'b0, 1'b0, 4'h5});
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus4.in_ready, 1);
        @(negedge clk);
        check("bp_not_consumed_busy", bus4.busy, 0);
        check("bp_result_kept", bus4.s, 4'h5);

        // Reset on the 2nd RUN cycle of 9 + 6
        bus4.a = 4'h9; bus4.b = 4'h6; bus4.ci = 1'b0; bus4.sub = 1'b0;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_s",        bus4.s,        0);
        check("mrst_co",       bus4.co,       0);
        check("mrst_busy",     bus4.busy,     0);
        check("mrst_in_ready", bus4.in_ready, 1);
        saw_ov = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (bus4.out_valid) saw_ov++;
        end
        check("mrst_no_out_valid", saw_ov, 0);

        // 5 - 7 (or 5 + 7 when subtraction is not built in)
        op4(4'h5, 4'h7, 1'b0, 1'b1, lat);
        if (SUB_EN) begin
            check("sub_result", {bus4.ovf, bus4.co, bus4.s}, {1'b0, 1'b0, 4'hE});
        end else begin
            check("sub_result", {bus4.ovf, bus4.co, bus4.s}, {1'b1, 1'b0, 4'hC});
        end

        // Small table against the reference model
        foreach (tbl[i]) begin
            op4(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, lat);
            check("tbl_latency", lat, W);
            check("tbl_result", {bus4.ovf, bus4.co, bus4.s},
                  model_op(int'(tbl[i].a), int'(tbl[i].b), tbl[i].ci, tbl[i].sub));
        end

        // WIDTH=8: 0x80 + 0x80
        @(negedge clk);
        guard = 0;
        while (!bus8.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus8.a = 8'h80; bus8.b = 8'h80; bus8.ci = 1'b0; bus8.in_valid = 1'b1;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("w8_latency", lat, W8);
        check("w8_s",   bus8.s,   8'h00);
        check("w8_co",  bus8.co,  1'b1);
        check("w8_ovf", bus8.ovf, 1'b1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
